// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: the controller state type and
//   the width of its encoding.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    // Width of the FSM state encoding (three states fit in two bits).
    localparam int unsigned STATE_W = 2;

    // IDLE : waiting for operands, in_ready high
    // RUN  : one sum bit produced per clock, LSB first
    // DONE : result held on sum/cout until out_ready
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
//   Single combinational full-adder cell.
//   Ports:
//     a, b  : operand bits
//     ci    : carry in
//     s     : sum bit   (a ^ b ^ ci)
//     co    : carry out (majority of a, b, ci)
// -----------------------------------------------------------------------------
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule : fa_cell

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder: {cout, sum} = a + b + cin computed LSB-first, one bit per
//   clock, through one full-adder cell and a registered carry.
//   Ports:
//     clk, rst    : rising-edge clock, asynchronous active-high reset
//     in_valid    : operand set presented
//     in_ready    : block can accept operands (IDLE and not in reset)
//     a, b, cin   : operands and carry-in, captured on acceptance
//     out_valid   : result available (DONE)
//     out_ready   : downstream accepts result
//     sum, cout   : result, driven only while out_valid, zero otherwise
//     busy        : high in RUN or DONE
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
    logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
    logic               carry_q,  carry_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;

    logic               fa_s;
    logic               fa_co;

    fa_cell u_fa (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    sum_sr_d = '0;
                    carry_d  = cin;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end

            RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                // New bit enters at the MSB; after WIDTH shifts the first
                // (LSB) result bit has arrived at position 0.
                sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
                carry_d  = fa_co;
                // Counter parks at the last index instead of incrementing
                // past it, so it never wraps inside an operation.
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs. in_ready is gated by rst so it reads 0 while reset is held.
    // sum/cout are masked outside DONE so no partial result is ever visible.
    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        sum       = out_valid ? sum_sr_q : '0;
        cout      = out_valid & carry_q;
    end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [W:0] exp_q[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] ref_add(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        check_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
            $error("check %s", tag);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [W:0] e;
        if (exp_q.size() == 0) begin
            check(tag, 32'hDEAD, 32'hE0E0);  // unexpected result: no entry queued
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'({cout, sum}), 32'(e));
        end
    endtask

    // Present operands (already checked to be acceptable) and take them on the next edge.
    task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        a = x; b = y; cin = c; in_valid = 1'b1;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        tick();
        exp_q.push_back(ref_add(x, y, c));
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int edges);
        edges = 0;
        while (!out_valid && edges < 64) begin
            tick();
            edges++;
        end
    endtask

    task automatic drain(input string tag);
        pop_check(tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_after_drain_out_valid", 32'(out_valid), 32'd0);
        check("idle_after_drain_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int edges;
        int ov_seen;
        int both_high;
        int acc, res, cyc;
        int acc_cyc[4];
        logic [W-1:0] sa[4];
        logic [W-1:0] sb[4];
        logic         sc[4];
        logic [W:0]   held;
        logic         took;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;

        // Reset held for 3 cycles
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        tick(); tick(); tick();
        check("rst_in_ready_late", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_sum_cout", 32'({cout, sum}), 32'd0);

        // Full-width carry ripple, latency exactly W edges
        accept(8'hFF, 8'h01, 1'b0);
        check("busy_in_run", 32'(busy), 32'd1);
        check("in_ready_in_run", 32'(in_ready), 32'd0);
        wait_out(edges);
        check("latency_ff_01", 32'(edges), 32'(W));
        check("result_ff_01_direct", 32'({cout, sum}), 32'h100);
        drain("result_ff_01");

        accept(8'h3C, 8'h42, 1'b1);
        wait_out(edges);
        check("latency_3c_42", 32'(edges), 32'(W));
        drain("result_3c_42");

        accept(8'hFF, 8'hFF, 1'b1);
        wait_out(edges);
        check("result_ff_ff_direct", 32'({cout, sum}), 32'h1FF);
        drain("result_ff_ff");

        // Backpressure in DONE with new operands waiting
        accept(8'h12, 8'h34, 1'b0);
        wait_out(edges);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        held = {cout, sum};
        a = 8'hA5; b = 8'h5A; cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_stable", 32'({cout, sum}), 32'(held));
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid_hold", 32'(out_valid), 32'd1);
        end
        pop_check("bp_result");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);
        check("bp_idle_busy", 32'(busy), 32'd0);
        tick();  // held operands taken on this edge
        exp_q.push_back(ref_add(8'hA5, 8'h5A, 1'b1));
        in_valid = 1'b0;
        check("bp_held_accepted", 32'(busy), 32'd1);
        wait_out(edges);
        check("bp_held_latency", 32'(edges), 32'(W));
        drain("bp_held_result");

        // Reset after 3 bits processed
        accept(8'h55, 8'h66, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        ov_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) ov_seen++;
            tick();
        end
        check("midrst_no_out_valid", 32'(ov_seen), 32'd0);
        accept(8'h10, 8'h20, 1'b0);
        wait_out(edges);
        check("after_rst_result_direct", 32'({cout, sum}), 32'h030);
        drain("after_rst_result");

        // Back-to-back with out_ready tied high
        for (int i = 0; i < 4; i++) begin
            sa[i] = W'($urandom_range(0, 255));
            sb[i] = W'($urandom_range(0, 255));
            sc[i] = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        a = sa[0]; b = sb[0]; cin = sc[0]; in_valid = 1'b1;
        acc = 0; res = 0; cyc = 0; both_high = 0;
        while ((acc < 4 || res < 4) && cyc < 200) begin
            took = 1'b0;
            if (in_ready && out_valid) both_high++;
            if (out_valid) begin
                pop_check("b2b_result");
                res++;
            end
            if (in_valid && in_ready) begin
                acc_cyc[acc] = cyc;
                exp_q.push_back(ref_add(sa[acc], sb[acc], sc[acc]));
                acc++;
                took = 1'b1;
            end
            tick();
            cyc++;
            if (took) begin
                if (acc < 4) begin
                    a = sa[acc]; b = sb[acc]; cin = sc[acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        check("b2b_results_count", 32'(res), 32'd4);
        check("b2b_accepts_count", 32'(acc), 32'd4);
        for (int i = 1; i < 4; i++) begin
            if (i < acc) check("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(W + 2));
        end
        check("b2b_no_overlap", 32'(both_high), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule : tb_serial_adder
